// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//
// Shared definitions for the instruction fetch stage:
//   - fetch_state_e     : FSM state encoding (request, hold-for-decode, drain)
//   - NOP_INSTR         : canonical RV32I NOP (addi x0, x0, 0)
//   - DEFAULT_RESET_PC  : default PC of the first fetch after reset
//   - align_target()    : force a redirect target onto a word boundary
//   - is_misaligned()   : flag a redirect target whose low bits are non-zero
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,  // request outstanding at fetch_pc
    FETCH_HOLD  = 2'd1,  // instruction held, offered to decode
    FETCH_DRAIN = 2'd2   // wrong-path request still in flight, waiting for ack
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Instruction memory is word addressed; the low two bits of a target are
  // dropped and reported separately through the misalign flag.
  function automatic logic [31:0] align_target(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the program counter, issues one word request
// at a time to instruction memory and hands the fetched word plus its PC to
// decode. Redirects from branch/jump resolution discard wrong-path fetches,
// including a request that is already in flight.
//
// Ports
//   clk_i          in   clock, rising edge
//   rst_i          in   synchronous active-high reset
//   imem_req_o     out  fetch request, held until imem_ack_i
//   imem_addr_o    out  word address of the request (stable while requesting)
//   imem_ack_i     in   memory response, imem_data_i valid in the same cycle
//   imem_data_i    in   fetched instruction word
//   redirect_i     in   one-cycle pulse: resume fetching at redirect_pc_i
//   redirect_pc_i  in   redirect target
//   instr_valid_o  out  instruction_o / pc_o valid for decode
//   instr_ready_i  in   decode accepts the instruction this cycle
//   instruction_o  out  instruction word to decode
//   pc_o           out  PC of instruction_o
//   misalign_o     out  one-cycle pulse: last redirect target had [1:0] != 0
//
// Handshakes
//   Memory side: a request is one cycle with imem_req_o=1 and imem_ack_i=1.
//   imem_addr_o never changes while imem_req_o=1 and no ack has been seen;
//   imem_ack_i is ignored whenever imem_req_o=0.
//   Decode side: a transfer is one cycle with instr_valid_o=1 and
//   instr_ready_i=1. While valid is high and ready is low, instruction_o and
//   pc_o hold. Valid is dropped combinationally in a redirect cycle, so a
//   killed instruction is never transferred.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction memory
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  // redirect from branch/jump resolution
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  // decode
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;      // address of next / in-flight request
  logic [31:0]  pending_pc_q, pending_pc_d;  // redirect target captured while draining
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  target;

  assign target = align_target(redirect_pc_i);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FETCH_REQ;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= 32'h0000_0000;
      instr_q      <= NOP_INSTR;
      instr_pc_q   <= 32'h0000_0000;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      instr_q      <= instr_d;
      instr_pc_q   <= instr_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    // A misaligned redirect is reported whatever state the FSM is in.
    misalign_d   = redirect_i & is_misaligned(redirect_pc_i);

    unique case (state_q)
      FETCH_REQ: begin
        if (imem_ack_i) begin
          if (redirect_i) begin
            // Response belongs to the wrong path; restart at the target.
            fetch_pc_d = target;
          end else begin
            instr_d    = imem_data_i;
            instr_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;  // wraps modulo 2^32
            state_d    = FETCH_HOLD;
          end
        end else if (redirect_i) begin
          // The request cannot be retracted: keep presenting the stale
          // address until memory answers, and remember where to go next.
          pending_pc_d = target;
          state_d      = FETCH_DRAIN;
        end
      end

      FETCH_HOLD: begin
        if (redirect_i) begin
          // Held instruction is on the wrong path; it is killed even if
          // decode is ready this cycle.
          fetch_pc_d = target;
          state_d    = FETCH_REQ;
        end else if (instr_ready_i) begin
          state_d = FETCH_REQ;
        end
      end

      FETCH_DRAIN: begin
        if (redirect_i) begin
          pending_pc_d = target;  // latest redirect wins
        end
        if (imem_ack_i) begin
          // Stale data is dropped; a redirect arriving with the ack is the
          // newest target and bypasses pending_pc.
          fetch_pc_d = redirect_i ? target : pending_pc_q;
          state_d    = FETCH_REQ;
        end
      end

      default: begin
        state_d = FETCH_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Reset gates the request and the flags immediately, so an in-flight
  // request is abandoned in the very cycle rst_i rises.
  assign imem_req_o    = ~rst_i & (state_q != FETCH_HOLD);
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = ~rst_i & (state_q == FETCH_HOLD) & ~redirect_i;
  assign instruction_o = instr_q;
  assign pc_o          = instr_pc_q;
  assign misalign_o    = ~rst_i & misalign_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural instruction memory with a
// programmable wait count answers requests with data = address + 0x0A00_0000.
// Expected decode transfers {pc, instruction} and expected acknowledged
// memory addresses are queued up front; two monitors pop and compare them as
// the DUT produces them. The stimulus thread adds cycle-exact checks on
// request/valid/misalign behaviour around waits, stalls, redirects and reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        misalign;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instruction_o (instruction),
    .pc_o          (pc),
    .misalign_o    (misalign)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [63:0] exp_q[$];       // {pc, instruction} per decode transfer
  logic [31:0] exp_addr_q[$];  // address of each acknowledged request
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_wait = 0;   // wait cycles before the memory acks
  int          mem_cnt  = 0;
  logic [63:0] e;
  logic [31:0] ea;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at the
  // falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  // ---------------------------------------------------------------------------
  // Instruction memory model (decides ack 2 units after the edge)
  // ---------------------------------------------------------------------------
  initial begin
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && imem_req) begin
        if (mem_cnt >= mem_wait) begin
          imem_ack  = 1'b1;
          imem_data = imem_addr + 32'h0A00_0000;
          mem_cnt   = 0;
        end else begin
          imem_ack = 1'b0;
          mem_cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        mem_cnt  = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL xfer_unexpected: got pc %h instr %h, expected no transfer", pc, instruction);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_pc", pc, e[63:32]);
          chk("xfer_instr", instruction, e[31:0]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL ack_unexpected: got addr %h, expected no acknowledged request", imem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("ack_addr", imem_addr, ea);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b1;

    // Acknowledged request addresses, in order.
    exp_addr_q.push_back(32'h0000_0000);
    exp_addr_q.push_back(32'h0000_0004);
    exp_addr_q.push_back(32'h0000_0008);
    exp_addr_q.push_back(32'h0000_000C);
    exp_addr_q.push_back(32'h0000_0010);
    exp_addr_q.push_back(32'h0000_0014);  // drained, data dropped
    exp_addr_q.push_back(32'h0000_0200);  // killed in HOLD
    exp_addr_q.push_back(32'h0000_0100);
    exp_addr_q.push_back(32'h0000_0104);  // ack together with redirect
    exp_addr_q.push_back(32'h0000_0000);  // after mid-operation reset
    // Decode transfers {pc, instruction}, in order.
    exp_q.push_back({32'h0000_0000, 32'h0A00_0000});
    exp_q.push_back({32'h0000_0004, 32'h0A00_0004});
    exp_q.push_back({32'h0000_0008, 32'h0A00_0008});
    exp_q.push_back({32'h0000_000C, 32'h0A00_000C});
    exp_q.push_back({32'h0000_0010, 32'h0A00_0010});
    exp_q.push_back({32'h0000_0100, 32'h0A00_0100});
    exp_q.push_back({32'h0000_0000, 32'h0A00_0000});

    // ---- reset ----
    tick(); settle();
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_misalign", misalign, 0);
    tick(); settle();
    chk("rst_instr_nop", instruction, 32'h0000_0013);
    chk("rst_pc", pc, 32'h0);
    tick(); rst = 1'b0; settle();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", instr_valid, 0);
    chk("first_instr_nop", instruction, 32'h0000_0013);

    // ---- zero-wait memory, decode always ready ----
    for (int i = 0; i < 3; i++) begin
      chk("zw_req", imem_req, 1);
      chk("zw_addr", imem_addr, 32'(4 * i));
      tick();
      if (i == 2) mem_wait = 3;
      settle();
      chk("zw_valid", instr_valid, 1);
      chk("zw_hold_req", imem_req, 0);
      chk("zw_pc", pc, 32'(4 * i));
      chk("zw_instr", instruction, 32'h0A00_0000 + 32'(4 * i));
      tick(); settle();
    end

    // ---- memory waits 3 cycles on address 0xC ----
    for (int j = 0; j < 4; j++) begin
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 32'h0000_000C);
      chk("wait_valid", instr_valid, 0);
      if (j < 3) begin
        tick(); settle();
      end
    end
    tick(); mem_wait = 0; settle();
    chk("wait_valid_after_ack", instr_valid, 1);
    chk("wait_pc", pc, 32'h0000_000C);

    // ---- decode stalls 5 cycles in HOLD ----
    tick(); instr_ready = 1'b0; settle();
    chk("stall_req_addr", imem_addr, 32'h0000_0010);
    for (int k = 0; k < 5; k++) begin
      tick(); settle();
      chk("stall_valid", instr_valid, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_pc", pc, 32'h0000_0010);
      chk("stall_instr", instruction, 32'h0A00_0010);
    end
    tick(); instr_ready = 1'b1; mem_wait = 3; settle();
    chk("stall_release_valid", instr_valid, 1);
    tick(); settle();
    chk("next_req", imem_req, 1);
    chk("next_addr", imem_addr, 32'h0000_0014);

    // ---- two redirects while request to 0x14 waits ----
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0100; settle();
    chk("drain_addr_1", imem_addr, 32'h0000_0014);
    chk("drain_valid_1", instr_valid, 0);
    tick(); redirect_pc = 32'h0000_0200; settle();
    chk("drain_addr_2", imem_addr, 32'h0000_0014);
    chk("drain_req_2", imem_req, 1);
    tick(); redirect = 1'b0; mem_wait = 0; settle();
    chk("drain_addr_ack", imem_addr, 32'h0000_0014);
    chk("drain_valid_ack", instr_valid, 0);
    tick(); settle();
    chk("drain_new_req", imem_req, 1);
    chk("drain_new_addr", imem_addr, 32'h0000_0200);

    // ---- redirect in HOLD with decode ready ----
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0100; settle();
    chk("hold_kill_valid", instr_valid, 0);
    tick(); redirect = 1'b0; settle();
    chk("hold_redir_req", imem_req, 1);
    chk("hold_redir_addr", imem_addr, 32'h0000_0100);
    tick(); settle();
    chk("hold_redir_valid", instr_valid, 1);

    // ---- misaligned redirect arriving with an ack, then reset in DRAIN ----
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0102; settle();
    chk("mis_before", misalign, 0);
    chk("mis_ack_addr", imem_addr, 32'h0000_0104);
    tick(); redirect = 1'b0; mem_wait = 3; settle();
    chk("mis_pulse", misalign, 1);
    chk("mis_fetch_addr", imem_addr, 32'h0000_0100);
    chk("mis_fetch_req", imem_req, 1);
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0300; settle();
    chk("mis_clear", misalign, 0);
    tick(); redirect = 1'b0; settle();
    chk("rstd_drain_addr", imem_addr, 32'h0000_0100);
    tick(); rst = 1'b1; settle();
    chk("rstd_req", imem_req, 0);
    chk("rstd_valid", instr_valid, 0);
    tick(); rst = 1'b0; mem_wait = 0; settle();
    chk("rstd_first_req", imem_req, 1);
    chk("rstd_first_addr", imem_addr, 32'h0);
    chk("rstd_instr_nop", instruction, 32'h0000_0013);
    chk("rstd_pc", pc, 32'h0);
    tick(); mem_wait = 1000; settle();
    chk("rstd_valid_after", instr_valid, 1);
    tick(); settle();
    chk("rstd_next_addr", imem_addr, 32'h0000_0004);
    tick(); tick(); settle();

    chk("xfer_queue_empty", 32'(exp_q.size()), 0);
    chk("addr_queue_empty", 32'(exp_addr_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_unit
